// File: rtl/gf_inv_seq.sv
// Sequential GF(2^M) inverter: computes a^(2^M-2) by square-and-multiply,
// one squaring and one multiplication per clock, with valid/ready on both sides.
module gf_inv_seq #(
  parameter int         M    = 8,
  parameter logic [M:0] POLY = 'h11B
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data,
  output logic         out_zero
);

  localparam int            CW   = $clog2(M);
  localparam logic [CW-1:0] LAST = CW'(M - 2);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [M-1:0]  s_q, s_d;
  logic [M-1:0]  r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          zflag_q, zflag_d;
  logic [M-1:0]  sq_s;
  logic          accept;

  // Horner-style shift-and-add; the reduction is folded into each shift.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M-1:0] p;
    p = '0;
    for (int i = M - 1; i >= 0; i--) begin
      p = {p[M-2:0], 1'b0} ^ (p[M-1] ? POLY[M-1:0] : '0);
      if (y[i]) p = p ^ x;
    end
    return p;
  endfunction

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign out_data  = r_q;
  assign out_zero  = zflag_q & out_valid;
  assign sq_s      = gf_mul(s_q, s_q);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    zflag_d = zflag_q;
    case (state_q)
      CALC: begin
        s_d   = sq_s;
        r_d   = gf_mul(r_q, sq_s);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: ;
    endcase
    // An accept in DONE overrides the return to IDLE (back-to-back operation).
    if (accept) begin
      s_d     = in_data;
      r_d     = M'(1);
      cnt_d   = '0;
      zflag_d = (in_data == '0);
      state_d = CALC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      zflag_q <= zflag_d;
    end
  end

endmodule

// File: tb/tb_gf_inv_seq.sv
// Directed bench for gf_inv_seq: an M=8 (POLY 'h11B) and an M=4 (POLY 'h13)
// instance checked against hand-computed inverses and a reference field multiply.
module tb_gf_inv_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid8, in_ready8, out_valid8, out_ready8, out_zero8;
  logic [7:0] in_data8, out_data8;
  logic       in_valid4, in_ready4, out_valid4, out_ready4, out_zero4;
  logic [3:0] in_data4, out_data4;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  gf_inv_seq #(.M(8), .POLY(9'h11B)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_zero(out_zero8)
  );

  gf_inv_seq #(.M(4), .POLY(5'h13)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_zero(out_zero4)
  );

  // Reference multiply: full carry-less product, then reduce from the top bit down.
  function automatic int gmul(input int a, input int b, input int m, input int poly);
    int p;
    p = 0;
    for (int i = 0; i < m; i++) if (b[i]) p = p ^ (a << i);
    for (int i = 2 * m - 2; i >= m; i--) if (p[i]) p = p ^ (poly << (i - m));
    return p;
  endfunction

  task automatic send8(input logic [7:0] a, output int lat, output logic [7:0] res, output logic z);
    int guard;
    in_data8  = a;
    in_valid8 = 1'b1;
    guard     = 0;
    while (!in_ready8 && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 50) begin @(posedge clk); #1; lat++; end
    res = out_data8;
    z   = out_zero8;
  endtask

  task automatic send4(input logic [3:0] a, output int lat, output logic [3:0] res);
    int guard;
    in_data4  = a;
    in_valid4 = 1'b1;
    guard     = 0;
    while (!in_ready4 && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 50) begin @(posedge clk); #1; lat++; end
    res = out_data4;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid8 = 1'b1; in_data8 = 8'h53; out_ready8 = 1'b1;
    in_valid4 = 1'b1; in_data4 = 4'h2;  out_ready4 = 1'b1;
    #1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid8 !== 1'b0) $display("[TB] FAIL reset_out_valid8 got %b want 0", out_valid8); else passes++;
    checks++; if (out_data8 !== 8'h00) $display("[TB] FAIL reset_out_data8 got %h want 00", out_data8); else passes++;
    checks++; if (out_zero8 !== 1'b0) $display("[TB] FAIL reset_out_zero8 got %b want 0", out_zero8); else passes++;
    checks++; if (in_ready8 !== 1'b1) $display("[TB] FAIL reset_in_ready8 got %b want 1", in_ready8); else passes++;
    checks++; if (out_valid4 !== 1'b0) $display("[TB] FAIL reset_out_valid4 got %b want 0", out_valid4); else passes++;
    checks++; if (out_data4 !== 4'h0) $display("[TB] FAIL reset_out_data4 got %h want 0", out_data4); else passes++;
    checks++; if (in_ready4 !== 1'b1) $display("[TB] FAIL reset_in_ready4 got %b want 1", in_ready4); else passes++;
    in_valid8 = 1'b0;
    in_valid4 = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    logic [7:0] ops [3] = '{8'h53, 8'h02, 8'h01};
    logic [7:0] exp [3] = '{8'hCA, 8'h8D, 8'h01};
    int lat;
    logic [7:0] res;
    logic z;
    for (int i = 0; i < 3; i++) begin
      send8(ops[i], lat, res, z);
      checks++; if (lat !== 7) $display("[TB] FAIL single_latency a=%h got %0d want 7", ops[i], lat); else passes++;
      checks++; if (res !== exp[i]) $display("[TB] FAIL single_data a=%h got %h want %h", ops[i], res, exp[i]); else passes++;
      checks++; if (z !== 1'b0) $display("[TB] FAIL single_zero a=%h got %b want 0", ops[i], z); else passes++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero;
    int lat;
    logic [7:0] res;
    logic z;
    send8(8'h00, lat, res, z);
    checks++; if (res !== 8'h00) $display("[TB] FAIL zero_data got %h want 00", res); else passes++;
    checks++; if (z !== 1'b1) $display("[TB] FAIL zero_flag got %b want 1", z); else passes++;
    @(posedge clk); #1;
    send8(8'h03, lat, res, z);
    checks++; if (res !== 8'hF6) $display("[TB] FAIL after_zero_data got %h want F6", res); else passes++;
    checks++; if (z !== 1'b0) $display("[TB] FAIL after_zero_flag got %b want 0", z); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat, guard, prod;
    out_ready8 = 1'b1;
    in_valid8  = 1'b1;
    for (int a = 1; a < 256; a++) begin
      in_data8 = 8'(a);
      guard = 0;
      while (!in_ready8 && guard < 50) begin @(posedge clk); #1; guard++; end
      @(posedge clk); #1;
      lat = 0;
      while (!out_valid8 && lat < 50) begin @(posedge clk); #1; lat++; end
      prod = gmul(a, int'(out_data8), 8, 'h11B);
      checks++; if (prod != 1 || out_zero8 !== 1'b0)
        $display("[TB] FAIL b2b_inverse a=%h got out=%h prod=%h zero=%b want prod=01 zero=0", a, out_data8, prod, out_zero8);
      else passes++;
      checks++; if (lat !== 7 || in_ready8 !== 1'b1)
        $display("[TB] FAIL b2b_timing a=%h got lat=%0d in_ready=%b want lat=7 in_ready=1", a, lat, in_ready8);
      else passes++;
    end
    in_valid8 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int lat;
    logic [7:0] res;
    logic z;
    logic hold_ok;
    out_ready8 = 1'b0;
    in_data8   = 8'h53;
    in_valid8  = 1'b1;
    @(posedge clk); #1;
    in_data8 = 8'h01;
    lat = 0;
    hold_ok = 1'b1;
    while (!out_valid8 && lat < 50) begin
      if (in_ready8 !== 1'b0) hold_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    checks++; if (hold_ok !== 1'b1) $display("[TB] FAIL bp_calc_in_ready got high want low"); else passes++;
    checks++; if (lat !== 7) $display("[TB] FAIL bp_latency got %0d want 7", lat); else passes++;
    checks++; if (out_data8 !== 8'hCA) $display("[TB] FAIL bp_data got %h want CA", out_data8); else passes++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid8 !== 1'b1 || out_data8 !== 8'hCA || in_ready8 !== 1'b0)
        $display("[TB] FAIL bp_hold cyc=%0d got valid=%b data=%h in_ready=%b want 1/CA/0", i, out_valid8, out_data8, in_ready8);
      else passes++;
    end
    in_data8   = 8'h02;
    out_ready8 = 1'b1;
    #1;
    checks++; if (in_ready8 !== 1'b1) $display("[TB] FAIL bp_release_in_ready got %b want 1", in_ready8); else passes++;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    checks++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b0)
      $display("[TB] FAIL bp_same_edge_accept got valid=%b in_ready=%b want 0/0", out_valid8, in_ready8);
    else passes++;
    lat = 0;
    while (!out_valid8 && lat < 50) begin @(posedge clk); #1; lat++; end
    res = out_data8;
    checks++; if (lat !== 7 || res !== 8'h8D)
      $display("[TB] FAIL bp_next_result got lat=%0d data=%h want 7/8D", lat, res);
    else passes++;
    @(posedge clk); #1;
    z = 1'b0;
  endtask

  task automatic test_reset_mid_calc;
    int lat;
    logic [7:0] res;
    logic z;
    logic stale;
    out_ready8 = 1'b1;
    in_data8   = 8'h53;
    in_valid8  = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid8 !== 1'b0 || out_data8 !== 8'h00 || out_zero8 !== 1'b0 || in_ready8 !== 1'b1)
      $display("[TB] FAIL midreset_outputs got valid=%b data=%h zero=%b in_ready=%b want 0/00/0/1",
               out_valid8, out_data8, out_zero8, in_ready8);
    else passes++;
    in_data8  = 8'h07;
    in_valid8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1)
      $display("[TB] FAIL midreset_hold got valid=%b in_ready=%b want 0/1", out_valid8, in_ready8);
    else passes++;
    in_valid8 = 1'b0;
    #1 rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid8 !== 1'b0) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) $display("[TB] FAIL midreset_stale_valid got 1 want 0"); else passes++;
    send8(8'h53, lat, res, z);
    checks++; if (res !== 8'hCA || lat !== 7)
      $display("[TB] FAIL midreset_recover got data=%h lat=%0d want CA/7", res, lat);
    else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_m4;
    int lat, prod;
    logic [3:0] res;
    out_ready4 = 1'b1;
    send4(4'h2, lat, res);
    checks++; if (res !== 4'h9) $display("[TB] FAIL m4_data got %h want 9", res); else passes++;
    checks++; if (lat !== 3) $display("[TB] FAIL m4_latency got %0d want 3", lat); else passes++;
    @(posedge clk); #1;
    for (int a = 1; a < 16; a++) begin
      send4(4'(a), lat, res);
      prod = gmul(a, int'(res), 4, 'h13);
      checks++; if (prod != 1 || lat !== 3)
        $display("[TB] FAIL m4_sweep a=%h got out=%h prod=%h lat=%0d want prod=1 lat=3", a, res, prod, lat);
      else passes++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_zero;
    test_back_to_back;
    test_backpressure;
    test_reset_mid_calc;
    test_m4;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
